// File: rtl/sparse_row_sequencer_pkg.sv
// Shared types and constants for the sparse row sequencer and the
// row-accumulate controller that consumes its tagged element stream.
package sparse_row_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        EMPTY  = 2'd2,
        DRAIN  = 2'd3
    } srs_state_e;

    localparam int VALID_TAG = 24;
    localparam int ELEM_W    = 25;
    localparam int VAL_W     = 24;

    localparam logic [ELEM_W-1:0] BUBBLE = 25'h0;

    // Build a valid beat: tag bit set above the product value.
    function automatic logic [ELEM_W-1:0] tag_elem(input logic [VAL_W-1:0] val);
        logic [ELEM_W-1:0] elem;
        elem            = {1'b1, val};
        return elem;
    endfunction

endpackage

// File: rtl/sparse_row_sequencer_if.sv
// Handshake and element-stream bundle between the feeder side and the
// sparse row sequencer.
interface sparse_row_sequencer_if #(
    parameter int NZE_W = 4,
    parameter int ROW_W = 8
);
    import sparse_row_sequencer_pkg::*;

    logic [NZE_W-1:0]  nze_in;
    logic              nze_valid;
    logic              nze_ready;
    logic [VAL_W-1:0]  val_in;
    logic              val_valid;
    logic              val_ready;
    logic [ELEM_W-1:0] element;
    logic              set_bit;
    logic              row_done;
    logic [ROW_W-1:0]  row_idx;
    logic              busy;

    modport master (
        output nze_in, nze_valid, val_in, val_valid,
        input  nze_ready, val_ready, element, set_bit, row_done, row_idx, busy
    );

    modport slave (
        input  nze_in, nze_valid, val_in, val_valid,
        output nze_ready, val_ready, element, set_bit, row_done, row_idx, busy
    );

endinterface

// File: rtl/sparse_row_sequencer_drain_timer.sv
// Loadable down-counter that holds the pipeline-flush gap after a row;
// done is high while running with the count exhausted.
module sparse_row_sequencer_drain_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             run,
    output logic             done
);

    logic [CNT_W-1:0] count_r;

    // Count register: load wins, otherwise count down and park at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (run && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = run && !load && (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/sparse_row_sequencer.sv
// Turns a per-row nonzero count plus a product stream into the tagged
// element stream for the row-accumulate controller, with a drain gap per row.
module sparse_row_sequencer
    import sparse_row_sequencer_pkg::*;
#(
    parameter int NZE_W     = 4,
    parameter int ROW_W     = 8,
    parameter int DRAIN_CYC = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    sparse_row_sequencer_if.slave bus
);

    localparam int DRAIN_W = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC);

    srs_state_e        state_r;
    srs_state_e        state_nxt_s;
    logic [NZE_W-1:0]  remaining_r;
    logic              first_r;
    logic [ELEM_W-1:0] element_r;
    logic              set_bit_r;
    logic              row_done_r;
    logic [ROW_W-1:0]  row_idx_r;
    logic              drain_load_s;
    logic              drain_run_s;
    logic              drain_done_s;
    logic              nze_zero_s;
    logic              last_elem_s;

    assign nze_zero_s  = (bus.nze_in == {NZE_W{1'b0}});
    assign last_elem_s = bus.val_valid && (remaining_r == NZE_W'(1));
    assign drain_run_s = (state_r == DRAIN);

    sparse_row_sequencer_drain_timer #(
        .CNT_W (DRAIN_W)
    ) u_drain_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (drain_load_s),
        .load_val (DRAIN_LOAD),
        .run      (drain_run_s),
        .done     (drain_done_s)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and drain-timer load strobe.
    always_comb begin
        state_nxt_s  = state_r;
        drain_load_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.nze_valid) begin
                    if (nze_zero_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = STREAM;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STREAM: begin
                if (last_elem_s) begin
                    state_nxt_s  = DRAIN;
                    drain_load_s = 1'b1;
                end else begin
                    state_nxt_s = STREAM;
                end
            end
            EMPTY: begin
                state_nxt_s  = DRAIN;
                drain_load_s = 1'b1;
            end
            DRAIN: begin
                if (drain_done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Row bookkeeping and registered outputs; every output defaults to a bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remaining_r <= {NZE_W{1'b0}};
            first_r     <= 1'b0;
            element_r   <= BUBBLE;
            set_bit_r   <= 1'b0;
            row_done_r  <= 1'b0;
            row_idx_r   <= {ROW_W{1'b0}};
        end else begin
            element_r  <= BUBBLE;
            set_bit_r  <= 1'b0;
            row_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.nze_valid && !nze_zero_s) begin
                        remaining_r <= bus.nze_in;
                        first_r     <= 1'b1;
                    end
                end
                STREAM: begin
                    // Bubbles keep first_r so set_bit rides the first real value.
                    if (bus.val_valid) begin
                        element_r   <= tag_elem(bus.val_in);
                        set_bit_r   <= first_r;
                        first_r     <= 1'b0;
                        remaining_r <= remaining_r - NZE_W'(1);
                    end
                end
                EMPTY: begin
                    element_r <= tag_elem({VAL_W{1'b0}});
                    set_bit_r <= 1'b1;
                end
                DRAIN: begin
                    if (drain_done_s) begin
                        row_done_r <= 1'b1;
                        row_idx_r  <= row_idx_r + ROW_W'(1);
                    end
                end
                default: begin
                    first_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.nze_ready = (state_r == IDLE);
    assign bus.val_ready = (state_r == STREAM);
    assign bus.busy      = (state_r != IDLE);
    assign bus.element   = element_r;
    assign bus.set_bit   = set_bit_r;
    assign bus.row_done  = row_done_r;
    assign bus.row_idx   = row_idx_r;

endmodule
